// File: rtl/weight_stream_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// weight_stream_ctrl_pkg
// Shared sizes and types for the weight streaming controller.
//   COEFF_WIDTH   : coefficient width in bits (default DATA_WIDTH)
//   KERN_S_SIZE   : coefficients in one kernel ROM image (default MEM_SIZE)
//   REP_WIDTH_DEF : default width of the pass-count input
//   wsc_state_e   : controller state encoding, also exported for debug
//   addr_bits()   : ROM address width for a given image depth (min 1 bit)
// ---------------------------------------------------------------------------
package weight_stream_ctrl_pkg;

  localparam int COEFF_WIDTH   = 16;
  localparam int KERN_S_SIZE   = 288;
  localparam int REP_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } wsc_state_e;

  // A depth of 1 still needs a 1-bit address port.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/weight_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// weight_stream_ctrl_if
// Groups the ROM read port and the downstream FIFO write port.
//   rom_address / rom_ce / rom_q : synchronous ROM, rom_q valid one cycle
//                                   after the cycle rom_ce is high
//   output_V_din / _write / _full_n : FIFO write side
//
// Handshake: a word transfers on a rising edge where output_V_write and
// output_V_full_n are both high. output_V_write acts as valid and
// output_V_full_n as ready; while write is held off (full_n low) the
// producer keeps output_V_din unchanged and never withdraws a pending word.
//
// Modports: master = controller side, slave = ROM + FIFO side.
// ---------------------------------------------------------------------------
interface weight_stream_ctrl_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0] rom_address;
  logic                  rom_ce;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] output_V_din;
  logic                  output_V_full_n;
  logic                  output_V_write;

  modport master (
    output rom_address,
    output rom_ce,
    input  rom_q,
    output output_V_din,
    input  output_V_full_n,
    output output_V_write
  );

  modport slave (
    input  rom_address,
    input  rom_ce,
    output rom_q,
    input  output_V_din,
    output output_V_full_n,
    input  output_V_write
  );

endinterface

// File: rtl/weight_skid_buf.sv
// ---------------------------------------------------------------------------
// weight_skid_buf
// Two-entry FIFO that catches ROM read data so reads can be issued ahead of
// downstream acceptance.
//   clk, rst : clock, asynchronous active-high reset (empties the buffer)
//   push     : write din this cycle (caller guarantees space)
//   pop      : drop the head word this cycle (caller guarantees non-empty)
//   din      : word to store
//   dout     : head word, combinational from storage, stable until popped
//   count    : occupancy 0..2
// Simultaneous push and pop leaves the occupancy unchanged.
// ---------------------------------------------------------------------------
module weight_skid_buf #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q,  count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/weight_stream_ctrl.sv
// ---------------------------------------------------------------------------
// weight_stream_ctrl
// Streams a kernel coefficient image from an external ROM into a FIFO,
// rep_count full passes per job, in strict address order.
//   ap_clk, ap_rst : clock, asynchronous active-high reset
//   start          : one-cycle job request, honoured only in IDLE
//   rep_count      : number of passes, sampled with start
//   busy           : job in progress (low again in the done cycle)
//   done           : one-cycle completion pulse
//   dbg_state      : current controller state
//   bus            : ROM read port + FIFO write port (master side)
//
// Flow: RUN issues ROM reads under a two-word credit limit; each returned
// word lands in a 2-entry skid buffer whose head drives the FIFO. DRAIN
// waits for the last read to return and the skid to empty.
// ---------------------------------------------------------------------------
module weight_stream_ctrl
  import weight_stream_ctrl_pkg::*;
#(
  parameter int MEM_SIZE   = KERN_S_SIZE,
  parameter int DATA_WIDTH = COEFF_WIDTH,
  parameter int REP_WIDTH  = REP_WIDTH_DEF
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 start,
  input  logic [REP_WIDTH-1:0] rep_count,
  output logic                 busy,
  output logic                 done,
  output wsc_state_e           dbg_state,
  weight_stream_ctrl_if.master bus
);

  localparam int             AW        = addr_bits(MEM_SIZE);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(MEM_SIZE - 1);

  wsc_state_e           state_q,    state_d;
  logic [AW-1:0]        addr_q,     addr_d;
  logic [REP_WIDTH-1:0] pass_q,     pass_d;
  logic [REP_WIDTH-1:0] rep_q,      rep_d;
  logic                 inflight_q, inflight_d;
  logic                 zdone_q,    zdone_d;

  logic                  drain_done;
  logic                  rom_ce;
  logic                  skid_pop;
  logic [1:0]            skid_count;
  logic [DATA_WIDTH-1:0] skid_dout;
  logic [2:0]            occ_after;

  // The ROM returns one cycle after rom_ce, so the word is pushed into the
  // skid on the edge that ends the cycle in which inflight_q is high.
  weight_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .push  (inflight_q),
    .pop   (skid_pop),
    .din   (bus.rom_q),
    .dout  (skid_dout),
    .count (skid_count)
  );

  assign skid_pop = (skid_count != 2'd0) && bus.output_V_full_n;

  // Credit check. Occupancy is taken after this cycle's transfer so a word
  // leaving the skid frees its slot for a read issued in the same cycle;
  // this is what sustains one word per cycle. Skid words plus reads in
  // flight never exceed two, so a returning word always has a slot.
  always_comb begin
    occ_after = {1'b0, skid_count} - {2'b00, skid_pop};
    rom_ce    = (state_q == ST_RUN) &&
                ((occ_after + {2'b00, inflight_q}) < 3'd2);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pass_d     = pass_q;
    rep_d      = rep_q;
    zdone_d    = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (rep_count != '0) begin
            state_d = ST_RUN;
            rep_d   = rep_count;
            addr_d  = '0;
            pass_d  = '0;
          end else begin
            // Empty job: answer with done next cycle and stay idle.
            zdone_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (rom_ce) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            pass_d = pass_q + REP_WIDTH'(1);
            if (pass_q == rep_q - REP_WIDTH'(1)) begin
              state_d = ST_DRAIN;
            end
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && (skid_count == 2'd0)) begin
          state_d    = ST_IDLE;
          drain_done = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign inflight_d = rom_ce;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      pass_q     <= '0;
      rep_q      <= '0;
      inflight_q <= 1'b0;
      zdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pass_q     <= pass_d;
      rep_q      <= rep_d;
      inflight_q <= inflight_d;
      zdone_q    <= zdone_d;
    end
  end

  // done and busy depend only on registered state, never on inputs.
  assign done      = zdone_q | drain_done;
  assign busy      = (state_q != ST_IDLE) && !drain_done;
  assign dbg_state = state_q;

  assign bus.rom_address    = addr_q;
  assign bus.rom_ce         = rom_ce;
  assign bus.output_V_din   = skid_dout;
  assign bus.output_V_write = skid_pop;

endmodule
